// File: rtl/b64bit_sub_pkg.sv
// Shared defaults, derived sizes and FSM state type for the sequential subtractor.
package b64bit_sub_pkg;

    localparam int SUB_WIDTH   = 64;
    localparam int SUB_SLICE_W = 16;
    localparam int SUB_NS      = SUB_WIDTH / SUB_SLICE_W;

    // Slice-index width; kept at least 1 bit so a single-slice build still has a counter.
    function automatic int idx_width(input int ns);
        return (ns > 1) ? $clog2(ns) : 1;
    endfunction

    localparam int SUB_IDX_W = idx_width(SUB_NS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/sub16_slice.sv
// Combinational SLICE_W-bit subtract with borrow-in/borrow-out.
module sub16_slice #(
    parameter int SLICE_W = 16
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] d,
    output logic               bout
);
    logic [SLICE_W:0] res;

    // One extra bit: its MSB is set exactly when a - b - bin goes negative.
    assign res       = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, bin};
    assign {bout, d} = res;

endmodule

// File: rtl/b64bit_seq_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: A - B - b_in, one SLICE_W slice per clock,
// LSB slice first, behind valid/ready handshakes on both sides.
// Optional feature macro: SUB_OVF_EN adds the signed-overflow output ovf.
import b64bit_sub_pkg::*;

module b64bit_seq_subtractor #(
    parameter int WIDTH   = SUB_WIDTH,
    parameter int SLICE_W = SUB_SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NS    = WIDTH / SLICE_W;
    localparam int IDX_W = idx_width(NS);

    sub_state_e                   state, state_nxt;
    logic [NS-1:0][SLICE_W-1:0]   a_q, b_q, diff_q;
    logic [IDX_W-1:0]             idx;
    logic                         borrow;
    logic [SLICE_W-1:0]           d_sl;
    logic                         borrow_nxt;
    logic                         last;

    assign last = (idx == IDX_W'(NS - 1));
    assign diff = diff_q;

    // The single slice subtractor walks the captured operands under idx.
    sub16_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .bin  (borrow),
        .d    (d_sl),
        .bout (borrow_nxt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs; DONE only releases, never captures.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and slice-by-slice borrow ripple; results hold outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            b_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= A;
                        b_q    <= B;
                        borrow <= b_in;
                        idx    <= '0;
                    end
                end
                RUN: begin
                    diff_q[idx] <= d_sl;
                    borrow      <= borrow_nxt;
                    idx         <= last ? '0 : idx + 1'b1;
                    if (last) b_out <= borrow_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_OVF_EN
    // Signed overflow: operand signs differ and the result sign departs from A's.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == RUN && last) begin
            ovf <= (a_q[NS-1][SLICE_W-1] != b_q[NS-1][SLICE_W-1]) &&
                   (d_sl[SLICE_W-1] != a_q[NS-1][SLICE_W-1]);
        end
    end
`endif

endmodule

// File: tb/tb_b64bit_seq_subtractor.sv
// Randomized self-checking bench for b64bit_seq_subtractor against an
// arithmetic reference model (wide integer subtraction).
module tb_b64bit_seq_subtractor;

    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic        b_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] diff;
    logic        b_out;
`ifdef SUB_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    b64bit_seq_subtractor dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out)
`ifdef SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the unsigned and signed values.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic bin,
                         output logic [63:0] d, output logic bo, output logic ov);
        logic [64:0]        wide;
        logic signed [65:0] s;
        wide = {1'b0, a} - {1'b0, b} - {64'd0, bin};
        d    = wide[63:0];
        bo   = ({1'b0, a} < ({1'b0, b} + {64'd0, bin}));
        s    = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, bin});
        ov   = (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -66'sh0_8000_0000_0000_0000);
    endtask

    // One operation: accept, measure latency, check result, apply `hold` cycles
    // of backpressure with ignored in_valid pulses, then hand off.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic bin, input int hold);
        logic [63:0] ed, d0;
        logic        eb, eo;
        int          cyc;
        model(a, b, bin, ed, eb, eo);
        chk({tag, ":in_ready_idle"}, 64'(in_ready), 64'd1);
        A = a; B = b; b_in = bin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = {$urandom, $urandom}; B = {$urandom, $urandom}; b_in = 1'($urandom);
        chk({tag, ":in_ready_run"}, 64'(in_ready), 64'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ":latency"}, 64'(cyc), 64'(NS));
        chk({tag, ":diff"}, diff, ed);
        chk({tag, ":b_out"}, 64'(b_out), 64'(eb));
`ifdef SUB_OVF_EN
        chk({tag, ":ovf"}, 64'(ovf), 64'(eo));
`endif
        d0 = diff;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            chk({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, ":hold_ready"}, 64'(in_ready), 64'd0);
            chk({tag, ":hold_diff"}, diff, d0);
            chk({tag, ":hold_bout"}, 64'(b_out), 64'(eb));
        end
        // Transfer edge; a concurrent in_valid must not be captured.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, ":post_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ":post_ready"}, 64'(in_ready), 64'd1);
        chk({tag, ":post_diff"}, diff, d0);
    endtask

    initial begin
        logic [63:0] ra, rb;
        int          seen;
        #1;
        chk("rst:in_ready", 64'(in_ready), 64'd1);
        chk("rst:out_valid", 64'(out_valid), 64'd0);
        chk("rst:diff", diff, 64'd0);
        chk("rst:b_out", 64'(b_out), 64'd0);
`ifdef SUB_OVF_EN
        chk("rst:ovf", 64'(ovf), 64'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("zero", 64'd0, 64'd0, 1'b0, 0);
        run_op("one_one", 64'd1, 64'd1, 1'b0, 1);
        run_op("ripple", 64'd0, 64'd1, 1'b0, 0);
        run_op("alt", 64'h5555, 64'hAAAA, 1'b0, 2);
        run_op("ones_bin", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3);
        run_op("ovf_neg", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 0);
        run_op("small", 64'd5, 64'd3, 1'b0, 0);
        run_op("min_bin", 64'h8000_0000_0000_0000, 64'd0, 1'b1, 1);

        // Reset during the second RUN cycle aborts the operation.
        A = 64'd100; B = 64'd7; b_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort:in_ready", 64'(in_ready), 64'd1);
        chk("abort:out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort:no_result", 64'(seen), 64'd0);
        run_op("after_abort", 64'd100, 64'd7, 1'b0, 0);

        // Random operations, with some equal/near-equal operands.
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra + 64'($urandom_range(0, 2));
                default: rb = {$urandom, $urandom};
            endcase
            run_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
